// File: rtl/tl_pkg.sv
// tl_pkg: shared phase/requester types and round-robin helper for intersection_scheduler
package tl_pkg;
    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5,
        FLASH     = 3'd6
    } phase_t;
    typedef enum logic [1:0] {
        NS  = 2'd0,
        EW  = 2'd1,
        PED = 2'd2
    } requester_t;
    // Nearest pending requester after last in NS->EW->PED order; NS when none pend.
    // pend is indexed by requester_t.
    function automatic requester_t rr_grant(input requester_t last, input logic [2:0] pend);
        requester_t c;
        rr_grant = NS;
        for (int i = 3; i >= 1; i--) begin
            c = requester_t'(2'((int'(last) + i) % 3));
            if (pend[c]) rr_grant = c;
        end
    endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICK_DIV cycles
// Ports: clk, rst_n (async, active-low); tick high while the count equals TICK_DIV-1.
module tick_prescaler #(
    parameter int TICK_DIV = 27_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] r_cnt;
    assign tick = r_cnt == W'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= tick ? '0 : r_cnt + W'(1);
    end
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: shares one green among NS road, EW road and a pedestrian crossing
// Macro TL_NIGHT_FLASH_EN adds input night and a flashing-yellow FLASH phase.
// Ports: clk, rst_n (async, active-low); car_ns/car_ew sensor levels; ped_req button;
//        ns_*/ew_* red/yellow/green lamps, walk lamp, ped_wait latch, phase debug code.
module intersection_scheduler
    import tl_pkg::*;
#(
    parameter int TICK_DIV  = 27_000_000,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_ns,
    input  logic       car_ew,
    input  logic       ped_req,
`ifdef TL_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] phase
);
    localparam int EMAX = GREEN_MAX > WALK_T ? GREEN_MAX : WALK_T;
    localparam int EWID = $clog2(EMAX + 1);
    if (TICK_DIV < 1 || GREEN_MIN < 1 || GREEN_MAX < 1 || YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1) begin : g_bad_param
        $error("intersection_scheduler: every timing parameter must be >= 1");
    end
    phase_t          r_phase;
    requester_t      r_last;
    logic [EWID-1:0] r_elapsed;
    logic            r_ped_wait;
    phase_t          w_next;
    requester_t      w_last_next;
    logic            w_tick;
    logic [31:0]     w_el1;
    logic            w_ns_go;
    logic            w_ew_go;
    logic            w_ped_enter;
    logic            w_ped_open;
    logic            w_fl;
    logic            w_fy;
    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );
    // Ticks completed in the current phase, counting the tick now being taken.
    assign w_el1   = 32'(r_elapsed) + 32'd1;
    assign w_ns_go = (car_ew || r_ped_wait) && (w_el1 >= 32'(GREEN_MAX) || (w_el1 >= 32'(GREEN_MIN) && !car_ns));
    assign w_ew_go = (car_ns || r_ped_wait) && (w_el1 >= 32'(GREEN_MAX) || (w_el1 >= 32'(GREEN_MIN) && !car_ew));
    always_comb begin
        w_next      = r_phase;
        w_last_next = r_last;
        case (r_phase)
            ALL_RED:
                if (w_el1 >= 32'(ALLRED_T)) begin
                    w_last_next = rr_grant(r_last, {r_ped_wait, car_ew, car_ns});
                    w_next      = w_last_next == NS ? NS_GREEN : w_last_next == EW ? EW_GREEN : PED_WALK;
                end
            NS_GREEN:  w_next = w_ns_go ? NS_YELLOW : NS_GREEN;
            NS_YELLOW: w_next = w_el1 >= 32'(YELLOW_T) ? ALL_RED : NS_YELLOW;
            EW_GREEN:  w_next = w_ew_go ? EW_YELLOW : EW_GREEN;
            EW_YELLOW: w_next = w_el1 >= 32'(YELLOW_T) ? ALL_RED : EW_YELLOW;
            PED_WALK:  w_next = w_el1 >= 32'(WALK_T) ? ALL_RED : PED_WALK;
            default:   w_next = ALL_RED;
        endcase
`ifdef TL_NIGHT_FLASH_EN
        if (night) begin
            w_next      = FLASH;
            w_last_next = r_last;
        end
`endif
    end
    assign w_ped_enter = w_tick && w_next == PED_WALK && r_phase != PED_WALK;
`ifdef TL_NIGHT_FLASH_EN
    logic r_flash;
    assign w_ped_open = r_phase != PED_WALK && r_phase != FLASH;
    assign w_fl       = r_phase == FLASH;
    assign w_fy       = w_fl && r_flash;
    // Re-armed to 1 on every tick outside FLASH so the first flash tick shows yellow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_flash <= 1'b1;
        else if (w_tick) r_flash <= w_fl ? !r_flash : 1'b1;
    end
`else
    assign w_ped_open = r_phase != PED_WALK;
    assign w_fl       = 1'b0;
    assign w_fy       = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= ALL_RED;
            r_last     <= PED;
            r_elapsed  <= '0;
            r_ped_wait <= 1'b0;
        end else begin
            if (w_tick) begin
                r_phase   <= w_next;
                r_last    <= w_last_next;
                r_elapsed <= w_next != r_phase ? '0 : r_elapsed == EWID'(EMAX) ? r_elapsed : r_elapsed + EWID'(1);
            end
            r_ped_wait <= w_ped_enter ? 1'b0 : (ped_req && w_ped_open) ? 1'b1 : r_ped_wait;
        end
    end
    assign ns_green  = r_phase == NS_GREEN;
    assign ns_yellow = r_phase == NS_YELLOW || w_fy;
    assign ns_red    = !(ns_green || r_phase == NS_YELLOW || w_fl);
    assign ew_green  = r_phase == EW_GREEN;
    assign ew_yellow = r_phase == EW_YELLOW || w_fy;
    assign ew_red    = !(ew_green || r_phase == EW_YELLOW || w_fl);
    assign walk      = r_phase == PED_WALK;
    assign ped_wait  = r_ped_wait;
    assign phase     = r_phase;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: scoreboard bench with a tick-level reference model of the controller
module tb_intersection_scheduler;
    import tl_pkg::*;
    localparam int TICK_DIV  = 4;
    localparam int GREEN_MIN = 3;
    localparam int GREEN_MAX = 6;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 4;
    localparam int EMAX      = GREEN_MAX > WALK_T ? GREEN_MAX : WALK_T;
    logic clk = 1'b0;
    logic rst_n;
    logic car_ns, car_ew, ped_req;
    logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait;
    logic [2:0] phase;
`ifdef TL_NIGHT_FLASH_EN
    logic night = 1'b0;
`endif
    int n_chk = 0;
    int n_fail = 0;
    logic [10:0] q[$];
    phase_t m_ph;
    int m_el, m_last, m_cyc;
    logic m_pw, m_fl;
    always #5 clk = ~clk;
    intersection_scheduler #(
        .TICK_DIV(TICK_DIV), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .car_ns(car_ns), .car_ew(car_ew), .ped_req(ped_req),
`ifdef TL_NIGHT_FLASH_EN
        .night(night),
`endif
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .ped_wait(ped_wait), .phase(phase)
    );
    // Expected {ns r,y,g, ew r,y,g, walk, ped_wait, phase}: unnamed lamps are red, flash shows only yellows.
    function automatic logic [10:0] expv(input phase_t p, input logic pw, input logic fl);
        logic f;
        f = p == FLASH;
        return {!(p == NS_GREEN || p == NS_YELLOW || f), p == NS_YELLOW || (f && fl), p == NS_GREEN,
                !(p == EW_GREEN || p == EW_YELLOW || f), p == EW_YELLOW || (f && fl), p == EW_GREEN,
                p == PED_WALK, pw, 3'(p)};
    endfunction
    task automatic m_reset();
        m_ph = ALL_RED; m_el = 0; m_last = 2; m_pw = 1'b0; m_fl = 1'b1; m_cyc = 0;
    endtask
    // Requesters 0=NS 1=EW 2=PED; served queue is rotated so last_served sits at the back.
    task automatic m_step();
        bit tk;
        phase_t nx;
        int e1, g, last_n;
        int order[$];
        bit [2:0] pend;
        logic night_now;
        tk = (m_cyc % TICK_DIV) == TICK_DIV - 1;
        m_cyc++;
        nx = m_ph; e1 = m_el + 1; last_n = m_last;
        night_now = 1'b0;
`ifdef TL_NIGHT_FLASH_EN
        night_now = night;
`endif
        if (tk) begin
            if (m_ph == ALL_RED && e1 >= ALLRED_T) begin
                order = '{0, 1, 2};
                while (order[2] != m_last) order.push_back(order.pop_front());
                pend = {m_pw, car_ew, car_ns};
                g = -1;
                foreach (order[i]) if (g < 0 && pend[order[i]]) g = order[i];
                if (g < 0) g = 0;
                nx = g == 0 ? NS_GREEN : g == 1 ? EW_GREEN : PED_WALK;
                last_n = g;
            end
            else if (m_ph == NS_GREEN && (car_ew || m_pw) && (e1 >= GREEN_MAX || (e1 >= GREEN_MIN && !car_ns))) nx = NS_YELLOW;
            else if (m_ph == EW_GREEN && (car_ns || m_pw) && (e1 >= GREEN_MAX || (e1 >= GREEN_MIN && !car_ew))) nx = EW_YELLOW;
            else if ((m_ph == NS_YELLOW || m_ph == EW_YELLOW) && e1 >= YELLOW_T) nx = ALL_RED;
            else if (m_ph == PED_WALK && e1 >= WALK_T) nx = ALL_RED;
            else if (m_ph == FLASH) nx = ALL_RED;
            if (night_now) begin
                nx = FLASH;
                last_n = m_last;
            end
        end
        if (tk && nx == PED_WALK && m_ph != PED_WALK) m_pw = 1'b0;
        else if (ped_req && m_ph != PED_WALK && m_ph != FLASH) m_pw = 1'b1;
        if (tk) m_fl = m_ph == FLASH ? !m_fl : 1'b1;
        if (tk) m_el = nx != m_ph ? 0 : (e1 > EMAX ? EMAX : e1);
        m_ph = nx;
        m_last = last_n;
    endtask
    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else m_step();
        q.push_back(expv(m_ph, m_pw, m_fl));
    end
    // Asynchronous reset changes the outputs before the next edge, so fix up the pending expectation.
    always @(negedge rst_n) begin
        m_reset();
        if (q.size() > 0) q[q.size() - 1] = expv(m_ph, m_pw, m_fl);
    end
    always @(negedge clk) begin
        logic [10:0] e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait, phase};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL lamps @%0t: got %b expected %b (ns_ryg ew_ryg walk ped_wait phase)", $time, a, e);
            end
        end
    end
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic ped_pulse();
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
    endtask
    task automatic wait_phase(input phase_t p, input string nm);
        for (int i = 0; i < 1000 && m_ph != p; i++) step(1);
        n_chk++;
        if (m_ph != p) begin
            n_fail++;
            $display("FAIL wait_%s: phase %0d after 1000 cycles, required %0d", nm, m_ph, p);
        end
    endtask
    initial begin
        rst_n = 1'b0; car_ns = 1'b0; car_ew = 1'b0; ped_req = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(220);
        car_ew = 1'b1;
        step(80);
        car_ns = 1'b1;
        step(120);
        car_ns = 1'b0; car_ew = 1'b0;
        step(10);
        wait_phase(NS_GREEN, "ns_green");
        ped_pulse();
        wait_phase(PED_WALK, "ped_walk");
        step(2);
        ped_pulse();
        step(40);
        car_ns = 1'b1; car_ew = 1'b1;
        repeat (8) begin
            ped_pulse();
            step(60);
        end
        repeat (150) begin
            car_ns  = 1'($urandom_range(0, 1));
            car_ew  = 1'($urandom_range(0, 1));
            ped_req = $urandom_range(0, 3) == 0;
            step($urandom_range(1, 30));
            ped_req = 1'b0;
            step($urandom_range(0, 4));
        end
        car_ns = 1'b1; car_ew = 1'b1;
        wait_phase(EW_YELLOW, "ew_yellow");
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait, phase} !== 11'b10010000000) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 10010000000", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_wait, phase});
        end
        step(2);
        rst_n = 1'b1;
        car_ns = 1'b0; car_ew = 1'b0;
        step(100);
`ifdef TL_NIGHT_FLASH_EN
        car_ew = 1'b1;
        wait_phase(EW_GREEN, "ew_green_night");
        night = 1'b1;
        step(30);
        night = 1'b0;
        step(60);
`endif
        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
